// File: rtl/ifu_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The fetch stage is the master; memory answers with ack/rdata.
interface ifu_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/ifu_fetch.sv
// MIPS fetch stage: owns the PC, fetches over a variable-latency req/ack bus,
// applies D-stage redirects with one delay slot and emits NOP bubbles while waiting.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             stall,
    input  logic             branch,
    input  logic [31:0]      npcout,
    output logic [31:0]      instr,
    output logic [31:0]      pc8,
    output logic             instr_valid,
    output logic             fetch_busy,
    output logic [CNT_W-1:0] bubble_cnt,
    ifu_fetch_if.master      imem
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [31:0]      pc_reg, pc_next;
    logic             pend_reg, pend_next;
    logic [31:0]      ptgt_reg, ptgt_next;
    logic [31:0]      buffer_reg, buffer_next;
    logic [CNT_W-1:0] bubble_cnt_reg, bubble_cnt_next;
    logic             consume;
    logic [31:0]      npc_aligned;
    logic             unused_npc_bits;

    assign npc_aligned     = {npcout[31:2], 2'b00};
    assign unused_npc_bits = ^npcout[1:0];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg      <= ST_START;
            pc_reg         <= RESET_PC;
            pend_reg       <= 1'b0;
            ptgt_reg       <= '0;
            buffer_reg     <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            pend_reg       <= pend_next;
            ptgt_reg       <= ptgt_next;
            buffer_reg     <= buffer_next;
            bubble_cnt_reg <= bubble_cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pend_next   = pend_reg;
        ptgt_next   = ptgt_reg;
        buffer_next = buffer_reg;
        pc_next     = pc_reg;
        imem.req    = 1'b0;
        imem.addr   = {pc_reg[31:2], 2'b00};
        instr       = '0;
        instr_valid = 1'b0;
        fetch_busy  = 1'b0;
        consume     = 1'b0;

        case (state_reg)
            ST_START: state_next = ST_WAIT;
            ST_WAIT: begin
                imem.req = 1'b1;
                if (imem.ack) begin
                    instr       = imem.rdata;
                    instr_valid = 1'b1;
                    if (stall) begin
                        buffer_next = imem.rdata;
                        state_next  = ST_HOLD;
                    end
                end else begin
                    fetch_busy = 1'b1;
                    // The outstanding fetch becomes the delay slot; redirect after it lands.
                    if (!stall && branch) begin
                        pend_next = 1'b1;
                        ptgt_next = npc_aligned;
                    end
                end
            end
            ST_HOLD: begin
                instr       = buffer_reg;
                instr_valid = 1'b1;
                if (!stall) state_next = ST_WAIT;
            end
            default: state_next = ST_START;
        endcase

        consume = instr_valid & ~stall;
        if (consume) begin
            pend_next = 1'b0;
            if (pend_reg)    pc_next = ptgt_reg;
            else if (branch) pc_next = npc_aligned;
            else             pc_next = pc_reg + 32'd4;
        end
    end

    always_comb begin
        bubble_cnt_next = bubble_cnt_reg;
        if (!instr_valid && !stall && (bubble_cnt_reg != {CNT_W{1'b1}}))
            bubble_cnt_next = bubble_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign pc8        = pc_reg + 32'd8;
    assign bubble_cnt = bubble_cnt_reg;

endmodule
